// File: rtl/epochtv1_vram_arb.sv
// Slot-based arbiter for the shared 16-bit VRAM bus. One access per CE slot.
// The CPU does byte accesses. The background and sprite fetchers do word reads.
// After each CPU slot an optional recovery slot is inserted. A wait counter
// gives the CPU top priority once it has been denied for MAX_WAIT slots.
module epochtv1_vram_arb #(
    parameter int unsigned RECOVER  = 1,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        RENDER,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [11:0] CPU_A,
    input  logic [7:0]  CPU_DI,
    output logic [7:0]  CPU_DO,
    output logic        CPU_ACK,
    input  logic        BG_REQ,
    input  logic [11:0] BG_A,
    output logic        BG_ACK,
    input  logic        SPR_REQ,
    input  logic [11:0] SPR_A,
    output logic        SPR_ACK,
    output logic [15:0] VID_D,
    output logic [11:0] VAA,
    output logic [11:0] VBA,
    input  logic [7:0]  VAD_I,
    input  logic [7:0]  VBD_I,
    output logic [7:0]  VAD_O,
    output logic [7:0]  VBD_O,
    output logic        nVARD,
    output logic        nVBRD,
    output logic        nVAWR,
    output logic        nVBWR
);

    typedef enum logic [1:0] {StIdle, StCpu, StVid, StRcv} state_t;

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [11:0] addr_q;
    logic        we_q;
    logic        sel_q;      // byte lane of the CPU access: 0 = A/low, 1 = B/high
    logic [7:0]  wdata_q;
    logic        vid_spr_q;  // current video slot belongs to the sprite fetcher
    logic [7:0]  wait_q;
    logic [7:0]  cpu_do_q;
    logic [15:0] vid_q;
    logic        cpu_ack_q, bg_ack_q, spr_ack_q;
    logic        grant_cpu, grant_bg, grant_spr;

    // Next slot selection: recovery after a CPU slot, else priority arbitration.
    always_comb begin
        state_d   = state_q;
        grant_cpu = 1'b0;
        grant_bg  = 1'b0;
        grant_spr = 1'b0;
        if (state_q == StCpu && RECOVER != 0) begin
            state_d = StRcv;
        end else begin
            if (CPU_REQ && wait_q >= MaxWait) begin
                grant_cpu = 1'b1;
            end else if (RENDER) begin
                if (BG_REQ)       grant_bg  = 1'b1;
                else if (SPR_REQ) grant_spr = 1'b1;
                else if (CPU_REQ) grant_cpu = 1'b1;
            end else begin
                if (CPU_REQ)      grant_cpu = 1'b1;
                else if (BG_REQ)  grant_bg  = 1'b1;
                else if (SPR_REQ) grant_spr = 1'b1;
            end
            if (grant_cpu)                  state_d = StCpu;
            else if (grant_bg || grant_spr) state_d = StVid;
            else                            state_d = StIdle;
        end
    end

    // Slot register, access latches, read-data capture and one-CLK acknowledges.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            we_q      <= 1'b0;
            sel_q     <= 1'b0;
            wdata_q   <= '0;
            vid_spr_q <= 1'b0;
            wait_q    <= '0;
            cpu_do_q  <= '0;
            vid_q     <= '0;
            cpu_ack_q <= 1'b0;
            bg_ack_q  <= 1'b0;
            spr_ack_q <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            bg_ack_q  <= 1'b0;
            spr_ack_q <= 1'b0;
            if (CE) begin
                state_q <= state_d;
                if (grant_cpu || !CPU_REQ) wait_q <= '0;
                else if (wait_q < MaxWait) wait_q <= wait_q + 8'd1;
                // The slot that is ending completes here.
                if (state_q == StCpu) begin
                    cpu_ack_q <= 1'b1;
                    if (!we_q) cpu_do_q <= sel_q ? VBD_I : VAD_I;
                end
                if (state_q == StVid) begin
                    vid_q     <= {VBD_I, VAD_I};
                    bg_ack_q  <= !vid_spr_q;
                    spr_ack_q <= vid_spr_q;
                end
                // The winner's access is latched for the slot that starts now.
                if (grant_cpu) begin
                    addr_q  <= {1'b0, CPU_A[11:1]};
                    we_q    <= CPU_WE;
                    sel_q   <= CPU_A[0];
                    wdata_q <= CPU_DI;
                end else if (grant_bg) begin
                    addr_q    <= BG_A;
                    we_q      <= 1'b0;
                    vid_spr_q <= 1'b0;
                end else if (grant_spr) begin
                    addr_q    <= SPR_A;
                    we_q      <= 1'b0;
                    vid_spr_q <= 1'b1;
                end
            end
        end
    end

    // Bus drive derived from the current slot; idle and recovery slots are quiet.
    always_comb begin
        VAA   = (state_q == StCpu || state_q == StVid) ? addr_q : 12'h000;
        VBA   = VAA;
        nVARD = !(state_q == StVid || (state_q == StCpu && !we_q));
        nVBRD = nVARD;
        nVAWR = !(state_q == StCpu && we_q && !sel_q);
        nVBWR = !(state_q == StCpu && we_q && sel_q);
    end

    assign VAD_O   = wdata_q;
    assign VBD_O   = wdata_q;
    assign CPU_DO  = cpu_do_q;
    assign VID_D   = vid_q;
    assign CPU_ACK = cpu_ack_q;
    assign BG_ACK  = bg_ack_q;
    assign SPR_ACK = spr_ack_q;

endmodule

// File: tb/tb_epochtv1_vram_arb.sv
// Bench for epochtv1_vram_arb. It drives directed scenarios and then random
// traffic. Results are compared against a slot-level reference model.
module tb_epochtv1_vram_arb;

    localparam int unsigned RECOVER  = 1;
    localparam int unsigned MAX_WAIT = 8;

    logic        CLK, RST, CE, RENDER;
    logic        CPU_REQ, CPU_WE;
    logic [11:0] CPU_A;
    logic [7:0]  CPU_DI, CPU_DO;
    logic        CPU_ACK, BG_REQ, BG_ACK, SPR_REQ, SPR_ACK;
    logic [11:0] BG_A, SPR_A, VAA, VBA;
    logic [15:0] VID_D;
    logic [7:0]  VAD_I, VBD_I, VAD_O, VBD_O;
    logic        nVARD, nVBRD, nVAWR, nVBWR;

    epochtv1_vram_arb #(.RECOVER(RECOVER), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .RENDER(RENDER),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_A(CPU_A), .CPU_DI(CPU_DI),
        .CPU_DO(CPU_DO), .CPU_ACK(CPU_ACK),
        .BG_REQ(BG_REQ), .BG_A(BG_A), .BG_ACK(BG_ACK),
        .SPR_REQ(SPR_REQ), .SPR_A(SPR_A), .SPR_ACK(SPR_ACK),
        .VID_D(VID_D), .VAA(VAA), .VBA(VBA), .VAD_I(VAD_I), .VBD_I(VBD_I),
        .VAD_O(VAD_O), .VBD_O(VBD_O),
        .nVARD(nVARD), .nVBRD(nVBRD), .nVAWR(nVAWR), .nVBWR(nVBWR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int    total = 0;
    int    bad   = 0;
    string step  = "init";
    int    cnt_cack, cnt_back, cnt_sack;

    // Reference model: who owns the current slot (0 none, 1 cpu, 2 bg, 3 spr).
    int          m_who;
    int          m_wait;
    logic [11:0] m_addr;
    logic        m_we, m_sel;
    logic [7:0]  m_wd, m_cpu_do;
    logic [15:0] m_vid;
    logic        e_cack, e_back, e_sack;

    task automatic model_reset();
        m_who = 0; m_wait = 0; m_addr = '0; m_we = 0; m_sel = 0;
        m_wd = '0; m_cpu_do = '0; m_vid = '0;
        e_cack = 0; e_back = 0; e_sack = 0;
    endtask

    // Apply one CE edge to the model using the inputs presented right now.
    task automatic model_edge();
        int win;
        int order [3];
        bit req [4];
        e_cack = 0; e_back = 0; e_sack = 0;
        if (m_who == 1) begin
            e_cack = 1;
            if (!m_we) m_cpu_do = m_sel ? VBD_I : VAD_I;
        end else if (m_who >= 2) begin
            m_vid = {VBD_I, VAD_I};
            if (m_who == 2) e_back = 1; else e_sack = 1;
        end
        win = 0;
        if (!(m_who == 1 && RECOVER != 0)) begin
            req[0] = 0; req[1] = CPU_REQ; req[2] = BG_REQ; req[3] = SPR_REQ;
            if (CPU_REQ && m_wait >= int'(MAX_WAIT)) order = '{1, 2, 3};
            else if (RENDER)                         order = '{2, 3, 1};
            else                                     order = '{1, 2, 3};
            foreach (order[i]) if (win == 0 && req[order[i]]) win = order[i];
        end
        if (win == 1 || !CPU_REQ)           m_wait = 0;
        else if (m_wait < int'(MAX_WAIT))   m_wait++;
        m_who = win;
        if (win == 1) begin
            m_addr = {1'b0, CPU_A[11:1]}; m_we = CPU_WE; m_sel = CPU_A[0]; m_wd = CPU_DI;
        end else if (win == 2) begin
            m_addr = BG_A; m_we = 0;
        end else if (win == 3) begin
            m_addr = SPR_A; m_we = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s [%s]: observed=%h expected=%h", tag, step, got, exp);
        end
    endtask

    task automatic check_all(input bit live);
        logic [11:0] ea;
        logic        cpu_rd;
        ea     = (m_who != 0) ? m_addr : 12'h000;
        cpu_rd = (m_who == 1) && !m_we;
        chk("CPU_ACK", 16'(CPU_ACK), 16'(live & e_cack));
        chk("BG_ACK",  16'(BG_ACK),  16'(live & e_back));
        chk("SPR_ACK", 16'(SPR_ACK), 16'(live & e_sack));
        chk("CPU_DO",  16'(CPU_DO),  16'(m_cpu_do));
        chk("VID_D",   VID_D,        m_vid);
        chk("VAA",     16'(VAA),     16'(ea));
        chk("VBA",     16'(VBA),     16'(ea));
        chk("VAD_O",   16'(VAD_O),   16'(m_wd));
        chk("VBD_O",   16'(VBD_O),   16'(m_wd));
        chk("nVARD",   16'(nVARD),   16'(!(m_who >= 2 || cpu_rd)));
        chk("nVBRD",   16'(nVBRD),   16'(!(m_who >= 2 || cpu_rd)));
        chk("nVAWR",   16'(nVAWR),   16'(!(m_who == 1 && m_we && !m_sel)));
        chk("nVBWR",   16'(nVBWR),   16'(!(m_who == 1 && m_we && m_sel)));
    endtask

    // One CE edge followed by `idle` CE-low clocks, checked throughout.
    task automatic slot(input int idle);
        model_edge();
        CE = 1'b1;
        @(posedge CLK); #1;
        CE = 1'b0;
        check_all(1);
        cnt_cack += int'(CPU_ACK);
        cnt_back += int'(BG_ACK);
        cnt_sack += int'(SPR_ACK);
        for (int i = 0; i < idle; i++) begin
            @(posedge CLK); #1;
            check_all(0);
        end
    endtask

    task automatic flush();
        CPU_REQ = 0; BG_REQ = 0; SPR_REQ = 0;
        slot(1);
        slot(1);
    endtask

    int found;

    initial begin
        RST = 1; CE = 0; RENDER = 0; CPU_REQ = 0; CPU_WE = 0; CPU_A = '0; CPU_DI = '0;
        BG_REQ = 0; BG_A = '0; SPR_REQ = 0; SPR_A = '0; VAD_I = '0; VBD_I = '0;
        cnt_cack = 0; cnt_back = 0; cnt_sack = 0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        step = "reset";
        check_all(0);
        RST = 0;

        // CPU write to the high byte, then a recovery slot that ignores BG.
        step = "cpu_write";
        RENDER = 0; CPU_REQ = 1; CPU_WE = 1; CPU_A = 12'h005; CPU_DI = 8'hA5;
        BG_REQ = 1; BG_A = 12'h0F0;
        slot(1);
        chk("wr_vba", 16'(VBA), 16'h0002);
        chk("wr_nvbwr", 16'(nVBWR), 16'h0000);
        chk("wr_nvawr", 16'(nVAWR), 16'h0001);
        CPU_REQ = 0;
        slot(1);
        chk("wr_ack", 16'(cnt_cack), 16'h0001);
        chk("rcv_quiet", 16'(VAA), 16'h0000);
        slot(1);
        chk("rcv_then_bg", 16'(VAA), 16'h00F0);
        flush();

        // Render: BG before SPR, SPR follows once BG stops asking.
        step = "bg_spr";
        RENDER = 1; BG_REQ = 1; SPR_REQ = 1; BG_A = 12'h123; SPR_A = 12'h456;
        cnt_back = 0; cnt_sack = 0;
        slot(1);
        chk("bg_first", 16'(VAA), 16'h0123);
        BG_REQ = 0; VAD_I = 8'h3C; VBD_I = 8'h5A;
        slot(1);
        chk("bg_vid", VID_D, 16'h5A3C);
        chk("bg_ack", 16'(cnt_back), 16'h0001);
        chk("spr_next", 16'(VAA), 16'h0456);
        SPR_REQ = 0;
        slot(1);
        chk("spr_ack", 16'(cnt_sack), 16'h0001);
        flush();

        // Starvation guard: CPU read wins on slot MAX_WAIT+1 under constant BG load.
        step = "starve";
        RENDER = 1; BG_A = 12'h100; BG_REQ = 1;
        CPU_REQ = 1; CPU_WE = 0; CPU_A = 12'h7FE;
        found = 0;
        for (int n = 1; n <= 20 && found == 0; n++) begin
            slot(1);
            if (nVARD == 1'b0 && VAA == 12'h3FF) found = n;
        end
        chk("starve_slot", 16'(found), 16'(MAX_WAIT + 1));
        VAD_I = 8'h11; VBD_I = 8'h22;
        slot(1);
        chk("starve_rd", 16'(CPU_DO), 16'h0011);
        flush();

        // RENDER=0 with CPU and BG both requesting every slot.
        step = "cpu_rcv";
        RENDER = 0; CPU_REQ = 1; CPU_WE = 0; CPU_A = 12'h201; BG_REQ = 1;
        cnt_cack = 0; cnt_back = 0;
        repeat (8) slot(1);
        chk("pat_cpu", 16'(cnt_cack), 16'h0004);
        chk("pat_bg_starved", 16'(cnt_back), 16'h0000);
        CPU_REQ = 0;
        slot(1);
        slot(1);
        chk("pat_bg_resumes", 16'(cnt_back), 16'h0001);
        flush();

        // CE held low for five clocks during a low-byte write.
        step = "ce_hold";
        RENDER = 0; CPU_REQ = 1; CPU_WE = 1; CPU_A = 12'h004; CPU_DI = 8'h3C;
        cnt_cack = 0;
        slot(5);
        chk("hold_nvawr", 16'(nVAWR), 16'h0000);
        chk("hold_noack", 16'(cnt_cack), 16'h0000);
        CPU_REQ = 0;
        slot(1);
        chk("hold_ack", 16'(cnt_cack), 16'h0001);
        flush();

        // Reset in the middle of a sprite slot aborts it without an acknowledge.
        step = "rst_mid";
        RENDER = 1; SPR_REQ = 1; SPR_A = 12'h777;
        slot(1);
        SPR_REQ = 0;
        RST = 1;
        @(posedge CLK); #1;
        RST = 0;
        model_reset();
        check_all(0);
        cnt_sack = 0;
        slot(1);
        chk("rst_no_spr_ack", 16'(cnt_sack), 16'h0000);

        // Random traffic.
        step = "random";
        for (int i = 0; i < 300; i++) begin
            RENDER  = 1'($urandom_range(0, 1));
            CPU_REQ = 1'($urandom_range(0, 1));
            CPU_WE  = 1'($urandom_range(0, 1));
            CPU_A   = 12'($urandom);
            CPU_DI  = 8'($urandom);
            BG_REQ  = 1'($urandom_range(0, 1));
            BG_A    = 12'($urandom);
            SPR_REQ = 1'($urandom_range(0, 1));
            SPR_A   = 12'($urandom);
            VAD_I   = 8'($urandom);
            VBD_I   = 8'($urandom);
            slot($urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
